// File: rtl/crossbar_pkg.sv
// ---------------------------------------------------------------------------
// crossbar_pkg
// Shared definitions for the barrel-shifter crossbar and its scheduler.
//   N      : number of crossbar ports
//   W      : data width per port (used by the data path, not the scheduler)
//   PTR_W  : width of a port index / shift value
//   state_e: scheduler state (ARB = choosing a shift, XFER = shift held)
//   mod_sub/mod_add: index arithmetic mod N. This is a plain modulo, so it
//   is correct for any N, including N that is not a power of two.
// ---------------------------------------------------------------------------
package crossbar_pkg;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int PTR_W = $clog2(N);

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_e;

    // (a - b) mod N, for a, b in [0, N-1]
    function automatic logic [PTR_W-1:0] mod_sub(input int a, input int b);
        return PTR_W'((a + N - b) % N);
    endfunction

    // (a + b) mod N, for a, b in [0, N-1]
    function automatic logic [PTR_W-1:0] mod_add(input int a, input int b);
        return PTR_W'((a + b) % N);
    endfunction

endpackage

// File: rtl/crossbar_shift_scheduler_if.sv
// ---------------------------------------------------------------------------
// crossbar_shift_scheduler_if
// Handshake bundle between the crossbar inputs/outputs and the scheduler.
//   req_valid[i] : input i has a beat pending
//   req_dest[i]  : destination output of input i (stable during a packet)
//   req_last[i]  : the pending beat of input i ends its packet
//   req_ready[i] : the beat of input i is accepted this cycle
//   out_ready[k] : output k can accept a beat
//   out_valid[k] : output k carries a valid beat this cycle
//   shift_o      : shift value for the barrel-shifter data path
//   busy         : a transfer is in progress
// Modports: master = traffic/crossbar side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface crossbar_shift_scheduler_if;
    import crossbar_pkg::*;

    logic [N-1:0]            req_valid;
    logic [N-1:0][PTR_W-1:0] req_dest;
    logic [N-1:0]            req_last;
    logic [N-1:0]            req_ready;
    logic [N-1:0]            out_ready;
    logic [N-1:0]            out_valid;
    logic [PTR_W-1:0]        shift_o;
    logic                    busy;

    modport master (
        output req_valid, req_dest, req_last, out_ready,
        input  req_ready, out_valid, shift_o, busy
    );

    modport slave (
        input  req_valid, req_dest, req_last, out_ready,
        output req_ready, out_valid, shift_o, busy
    );

endinterface

// File: rtl/crossbar_rr_shift_pick.sv
// ---------------------------------------------------------------------------
// crossbar_rr_shift_pick
// Combinational round-robin picker over shift values.
//   has_match[s] : shift s would serve at least one pending request
//   ptr          : first shift value to consider
//   pick         : first s in ptr, ptr+1, ... (mod N) with has_match[s]
//   found        : some shift has a match (pick is 0 when low)
// ---------------------------------------------------------------------------
module crossbar_rr_shift_pick
    import crossbar_pkg::*;
(
    input  logic [N-1:0]     has_match,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] pick,
    output logic             found
);

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && has_match[mod_add(int'(ptr), k)]) begin
                found = 1'b1;
                pick  = mod_add(int'(ptr), k);
            end
        end
    end

endmodule

// File: rtl/crossbar_shift_scheduler.sv
// ---------------------------------------------------------------------------
// crossbar_shift_scheduler
// Chooses a shift for the barrel-shifter crossbar (out[k] = in[(k+shift)%N])
// and runs the per-beat handshakes while that shift is held.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : allows a new arbitration to start (a transfer in progress
//                always completes)
//   bus        : handshake bundle (slave modport), see the interface file
// ARB picks the round-robin first shift serving a pending request and
// freezes the set of inputs it serves (grant). XFER keeps shift and grant
// fixed until every granted packet has sent its last beat.
// ---------------------------------------------------------------------------
module crossbar_shift_scheduler
    import crossbar_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    crossbar_shift_scheduler_if.slave    bus
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [N-1:0]     grant_q, grant_d;

    // match_mask[s][i]: input i is pending and shift s routes it to its dest
    logic [N-1:0][N-1:0] match_mask;
    logic [N-1:0]        has_match;
    logic [PTR_W-1:0]    pick;
    logic                found;
    logic                in_xfer;
    logic [N-1:0]        req_ready_c;
    logic [N-1:0]        out_valid_c;
    logic [N-1:0]        done_mask;

    genvar gs, gi;
    generate
        for (gs = 0; gs < N; gs++) begin : g_shift
            for (gi = 0; gi < N; gi++) begin : g_in
                assign match_mask[gs][gi] = bus.req_valid[gi] &&
                                            (bus.req_dest[gi] == mod_sub(gi, gs));
            end
            assign has_match[gs] = |match_mask[gs];
        end
    endgenerate

    crossbar_rr_shift_pick u_pick (
        .has_match (has_match),
        .ptr       (ptr_q),
        .pick      (pick),
        .found     (found)
    );

    assign in_xfer = (state_q == XFER);

    // Input i drives output (i - shift); output k is fed by input (k + shift).
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            assign req_ready_c[gi] = in_xfer && grant_q[gi] &&
                                     bus.out_ready[mod_sub(gi, int'(shift_q))];
            assign out_valid_c[gi] = in_xfer &&
                                     grant_q[mod_add(gi, int'(shift_q))] &&
                                     bus.req_valid[mod_add(gi, int'(shift_q))];
        end
    endgenerate

    assign done_mask     = bus.req_valid & req_ready_c & bus.req_last;

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.shift_o   = shift_q;
    assign bus.busy      = in_xfer;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            ARB: begin
                if (enable && found) begin
                    shift_d = pick;
                    grant_d = match_mask[pick];
                    state_d = XFER;
                end
            end
            XFER: begin
                // Every packet finishing on this edge is released together.
                grant_d = grant_q & ~done_mask;
                if (grant_d == '0) begin
                    state_d = ARB;
                    ptr_d   = mod_add(int'(shift_q), 1);
                end
            end
            default: begin
                state_d = ARB;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            shift_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_crossbar_shift_scheduler.sv
// ---------------------------------------------------------------------------
// tb_crossbar_shift_scheduler
// Directed scenarios followed by random traffic. A transaction-level model
// tracks which inputs are being served and by which shift; every cycle the
// DUT outputs are compared against it at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_crossbar_shift_scheduler;
    import crossbar_pkg::*;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    crossbar_shift_scheduler_if bus ();

    crossbar_shift_scheduler dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model state
    bit           m_busy;
    int           m_shift;
    int           m_ptr;
    bit           m_grant [N];
    // next model state, committed after the clock edge
    bit           n_busy;
    int           n_shift;
    int           n_ptr;
    bit           n_grant [N];
    // expected outputs this cycle
    logic [N-1:0] e_ready;
    logic [N-1:0] e_valid;

    // random traffic generators
    bit act  [N];
    int blen [N];
    int bdst [N];

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act_v, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_shift = 0;
        m_ptr   = 0;
        foreach (m_grant[i]) m_grant[i] = 1'b0;
    endfunction

    // The shift that carries input i to destination d: i - shift = d (mod N).
    function automatic int needed_shift(input int i, input int d);
        return (i - d + N) % N;
    endfunction

    // Compare this cycle's outputs with the model and work out its next state.
    task automatic cyc();
        bit found;
        bit any_left;
        int s;
        @(negedge clk);
        e_ready = '0;
        e_valid = '0;
        if (m_busy) begin
            for (int i = 0; i < N; i++)
                e_ready[i] = m_grant[i] && bus.out_ready[(i - m_shift + N) % N];
            for (int k = 0; k < N; k++)
                e_valid[k] = m_grant[(k + m_shift) % N] && bus.req_valid[(k + m_shift) % N];
        end
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        chk("busy",      32'(bus.busy),      32'(m_busy));
        if (m_busy) chk("shift_o", 32'(bus.shift_o), 32'(m_shift));

        n_busy  = m_busy;
        n_shift = m_shift;
        n_ptr   = m_ptr;
        foreach (m_grant[i]) n_grant[i] = m_grant[i];
        if (!m_busy) begin
            found = 1'b0;
            s     = 0;
            if (enable) begin
                for (int d = 0; d < N && !found; d++) begin
                    for (int i = 0; i < N; i++) begin
                        if (bus.req_valid[i] &&
                            needed_shift(i, int'(bus.req_dest[i])) == (m_ptr + d) % N) begin
                            found = 1'b1;
                            s     = (m_ptr + d) % N;
                        end
                    end
                end
            end
            if (found) begin
                n_busy  = 1'b1;
                n_shift = s;
                for (int i = 0; i < N; i++)
                    n_grant[i] = bus.req_valid[i] &&
                                 needed_shift(i, int'(bus.req_dest[i])) == s;
            end
        end else begin
            any_left = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && e_ready[i] && bus.req_last[i]) n_grant[i] = 1'b0;
                if (n_grant[i]) any_left = 1'b1;
            end
            if (!any_left) begin
                n_busy = 1'b0;
                n_ptr  = (m_shift + 1) % N;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        m_busy  = n_busy;
        m_shift = n_shift;
        m_ptr   = n_ptr;
        foreach (m_grant[i]) m_grant[i] = n_grant[i];
    endtask

    task automatic clr();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_dest  = '0;
        bus.out_ready = '1;
        enable        = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        foreach (act[i]) begin
            act[i]  = 1'b0;
            blen[i] = 0;
            bdst[i] = 0;
        end

        // ---- 1: reset with random inputs ----
        repeat (5) begin
            bus.req_valid = N'($urandom);
            bus.req_last  = N'($urandom);
            for (int i = 0; i < N; i++) bus.req_dest[i] = PTR_W'($urandom_range(N - 1));
            bus.out_ready = N'($urandom);
            enable        = 1'($urandom);
            @(negedge clk);
            chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_busy",      32'(bus.busy),      32'h0);
            chk("rst_shift",     32'(bus.shift_o),   32'h0);
        end
        clr();
        rst_n = 1'b1;
        repeat (3) begin cyc(); adv(); end

        // ---- 2: in0 -> out7, 3 beats ----
        bus.req_valid[0] = 1'b1; bus.req_dest[0] = 3'd7;
        cyc(); chk("t2_arb_busy", 32'(bus.busy), 32'h0); adv();
        cyc();
        chk("t2_shift", 32'(bus.shift_o),   32'h1);
        chk("t2_busy",  32'(bus.busy),      32'h1);
        chk("t2_ready", 32'(bus.req_ready), 32'h01);
        chk("t2_valid", 32'(bus.out_valid), 32'h80);
        adv();
        cyc(); adv();
        bus.req_last[0] = 1'b1;
        cyc(); chk("t2_last_ready", 32'(bus.req_ready), 32'h01); adv();
        clr();
        cyc(); chk("t2_end_busy", 32'(bus.busy), 32'h0); chk("t2_model_ptr", 32'(m_ptr), 32'h2); adv();

        // ---- 3: in0 -> out7 (2 beats) and in1 -> out0 (1 beat) share shift 1 ----
        bus.req_valid[0] = 1'b1; bus.req_dest[0] = 3'd7;
        bus.req_valid[1] = 1'b1; bus.req_dest[1] = 3'd0; bus.req_last[1] = 1'b1;
        cyc(); adv();
        cyc();
        chk("t3_shift", 32'(bus.shift_o),   32'h1);
        chk("t3_ready", 32'(bus.req_ready), 32'h03);
        chk("t3_valid", 32'(bus.out_valid), 32'h81);
        adv();
        bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0; bus.req_last[0] = 1'b1;
        cyc();
        chk("t3_hold_busy",  32'(bus.busy),      32'h1);
        chk("t3_hold_shift", 32'(bus.shift_o),   32'h1);
        chk("t3_hold_ready", 32'(bus.req_ready), 32'h01);
        adv();
        clr();
        cyc(); chk("t3_end_busy", 32'(bus.busy), 32'h0); adv();

        // ---- 4: conflict on out0, round-robin serves both ----
        do_reset();
        clr();
        bus.req_valid[0] = 1'b1; bus.req_dest[0] = 3'd0; bus.req_last[0] = 1'b1;
        bus.req_valid[1] = 1'b1; bus.req_dest[1] = 3'd0; bus.req_last[1] = 1'b1;
        cyc(); adv();
        cyc();
        chk("t4_shift0", 32'(bus.shift_o),   32'h0);
        chk("t4_ready0", 32'(bus.req_ready), 32'h01);
        adv();
        bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
        cyc(); chk("t4_arb_busy", 32'(bus.busy), 32'h0); adv();
        cyc();
        chk("t4_shift1", 32'(bus.shift_o),   32'h1);
        chk("t4_ready1", 32'(bus.req_ready), 32'h02);
        chk("t4_valid1", 32'(bus.out_valid), 32'h01);
        adv();
        clr();
        cyc(); adv();

        // ---- 5: backpressure on out7 mid-packet ----
        bus.req_valid[0] = 1'b1; bus.req_dest[0] = 3'd7;
        cyc(); adv();
        cyc(); adv();
        bus.out_ready[7] = 1'b0;
        repeat (2) begin
            cyc();
            chk("t5_stall_ready", 32'(bus.req_ready), 32'h0);
            chk("t5_stall_shift", 32'(bus.shift_o),   32'h1);
            adv();
        end
        bus.out_ready[7] = 1'b1;
        cyc(); chk("t5_resume_ready", 32'(bus.req_ready), 32'h01); adv();
        bus.req_last[0] = 1'b1;
        cyc(); adv();
        clr();
        cyc(); chk("t5_end_busy", 32'(bus.busy), 32'h0); adv();

        // ---- 6: reset during a transfer ----
        bus.req_valid[3] = 1'b1; bus.req_dest[3] = 3'd1;   // needs shift 2
        bus.req_valid[1] = 1'b1; bus.req_dest[1] = 3'd0;   // needs shift 1
        cyc(); adv();
        cyc(); chk("t6_shift2", 32'(bus.shift_o), 32'h2); adv();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(bus.req_ready), 32'h0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_busy",  32'(bus.busy),      32'h0);
        chk("t6_rst_shift", 32'(bus.shift_o),   32'h0);
        model_reset();
        rst_n = 1'b1;
        bus.req_last[1] = 1'b1;
        cyc(); adv();
        cyc();
        chk("t6_rearb_shift", 32'(bus.shift_o),   32'h1);
        chk("t6_rearb_ready", 32'(bus.req_ready), 32'h02);
        adv();
        bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0; bus.req_last[3] = 1'b1;
        cyc(); adv();
        cyc(); chk("t6_in3_shift", 32'(bus.shift_o), 32'h2); adv();
        clr();
        cyc(); adv();

        // ---- random traffic ----
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!act[i] && $urandom_range(2) == 0) begin
                    act[i]  = 1'b1;
                    bdst[i] = int'($urandom_range(N - 1));
                    blen[i] = 1 + int'($urandom_range(3));
                end
                bus.req_valid[i] = act[i] && ($urandom_range(5) != 0);
                bus.req_dest[i]  = PTR_W'(bdst[i]);
                bus.req_last[i]  = (blen[i] == 1);
                bus.out_ready[i] = ($urandom_range(3) != 0);
            end
            enable = ($urandom_range(9) != 0);
            cyc();
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && e_ready[i]) begin
                    blen[i]--;
                    if (blen[i] == 0) act[i] = 1'b0;
                end
            end
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
